jt1943_dwnld_pack: RTL and testbench
====================================

Name: jt1943_dwnld_pack

Overview:
- Download-side packer between the ioctl byte stream and the SDRAM programming port / PROM write strobes used by the 1943 core.
- Buffers incoming ioctl bytes in a small FIFO. Converts ROM bytes into word-addressed, byte-masked SDRAM writes with a valid/ack handshake. Routes PROM bytes into one-hot PROM write pulses.
- Reports download completion and FIFO overrun to the top level.

Parameters:
- PROM_START, 22'h50000, first ioctl byte address belonging to the PROM area; below it is SDRAM ROM data.
- PROM_CNT, 13, number of 256-byte PROMs laid out back to back from PROM_START.
- FIFO_AW, 2, FIFO address width; depth = 2**FIFO_AW entries.

Ports:
- clk  in  1  core clock; all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- downloading  in  1  high while a ROM download is in progress
- ioctl_addr  in  22  byte address of the incoming byte
- ioctl_data  in  8  incoming byte
- ioctl_wr  in  1  one-cycle strobe, byte valid
- prog_addr  out  22  SDRAM word address (ioctl_addr>>1)
- prog_data  out  8  byte to write
- prog_mask  out  2  active-low lane enable: 2'b10 = low byte, 2'b01 = high byte
- prog_we  out  1  SDRAM write request, held until prog_ack
- prog_ack  in  1  SDRAM accepted the current request
- prom_we  out  13  one-hot PROM write pulse, bit = PROM index
- prom_addr  out  8  PROM byte address
- prom_data  out  4  PROM nibble (ioctl_data[3:0])
- dwnld_done  out  1  one-cycle pulse when download has fully drained
- rom_ready  out  1  high after first completed download, until next download start
- overrun  out  1  sticky: a byte was dropped during the current download

Behaviour:
- Reset (async, rst_n=0): FIFO empty; prog_addr=0, prog_data=0, prog_mask=2'b11, prog_we=0, prom_we=0, prom_addr=0, prom_data=0, dwnld_done=0, rom_ready=0, overrun=0, FSM in IDLE. Reset mid-download drops all buffered bytes. Nothing is written after release until a new ioctl_wr.
- Input classification happens at enqueue. Each FIFO entry stores {is_prom, addr[21:0], data[7:0]}.
- Entries with ioctl_addr >= PROM_START + 256*PROM_CNT are discarded and not enqueued. This is not an overrun.
- Enqueue on ioctl_wr && downloading && !full. If ioctl_wr && downloading && full: drop the byte, set overrun.
- ioctl_wr while downloading=0 is ignored.
- Simultaneous enqueue and dequeue is allowed when full. Dequeue frees the slot in the same cycle, so no drop occurs.
- FSM states:
  - IDLE: if FIFO not empty, pop the head entry. A ROM entry goes to SDRAM; a PROM entry goes to PROM.
  - SDRAM: on entry, drive prog_addr=addr>>1, prog_data=data, prog_mask = addr[0] ? 2'b01 : 2'b10, prog_we=1. Hold all outputs stable. On the cycle prog_ack=1, deassert prog_we next cycle and go to IDLE. An ack present in the very first SDRAM cycle is honoured, so the minimum is 1 cycle of prog_we. prog_ack while prog_we=0 is ignored.
  - PROM: on entry, prom_addr=addr[7:0], prom_data=data[3:0], and prom_we[(addr-PROM_START)>>8]=1 for exactly one cycle. Then go to IDLE. prom_addr/prom_data hold their values afterwards.
- Latency: ioctl_wr to prog_we rise is 2 cycles with an empty FIFO (enqueue, pop). The same applies to the prom_we pulse. Maximum throughput is one entry per 2 cycles.
- Completion tracking:
  - A downloading 1->0 edge arms a done flag.
  - While armed, FIFO empty and FSM in IDLE: pulse dwnld_done for 1 cycle, set rom_ready=1, clear the arm.
  - A downloading 0->1 edge clears rom_ready and overrun, and clears the arm.
  - A new download starting while the FIFO still drains: buffered bytes still drain; no dwnld_done is issued for the aborted download.
- FIFO pointers are FIFO_AW+1 bits and wrap naturally. full = (wr_ptr ^ rd_ptr) == {1'b1, 0...}; empty = pointers equal.

Test Plan:
- Reset mid-transfer: assert rst_n=0 while prog_we=1 -> prog_we=0, prom_we=0, overrun=0, rom_ready=0 immediately (asynchronous); no SDRAM write after release.
- ROM byte: downloading=1, ioctl_wr with addr=22'h00123, data=8'hA5; ack after 3 cycles -> prog_we rises 2 cycles after the strobe, prog_addr=22'h00091, prog_mask=2'b01, prog_data=8'hA5, held 3 cycles; drops the cycle after ack.
- PROM byte: ioctl_wr with addr=PROM_START+22'h205, data=8'h3C -> prom_we=13'h0004 for 1 cycle, prom_addr=8'h05, prom_data=4'hC, prog_we stays 0.
- Overrun: hold prog_ack=0, send 6 ROM strobes 1 cycle apart -> first popped and in flight, next 4 buffered, 6th dropped, overrun=1; after ack, 4 more writes complete in order.
- Completion: drop downloading while 2 entries are queued -> dwnld_done pulses exactly once, only after the last ack; rom_ready=1 afterwards; next downloading rise clears rom_ready and overrun.
- Out-of-range: addr=PROM_START+13*256 -> no prom_we, no prog_we, no overrun.

Source files
------------

// File: rtl/jt1943_dwnld_pack.sv
// Download packer: buffers ioctl bytes, turns ROM bytes into byte-masked SDRAM
// writes (valid/ack) and PROM bytes into one-hot PROM write pulses.
module jt1943_dwnld_pack #(
  parameter logic [21:0] PROM_START = 22'h50000,
  parameter int          PROM_CNT   = 13,
  parameter int          FIFO_AW    = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                downloading,
  input  logic [21:0]         ioctl_addr,
  input  logic [7:0]          ioctl_data,
  input  logic                ioctl_wr,
  output logic [21:0]         prog_addr,
  output logic [7:0]          prog_data,
  output logic [1:0]          prog_mask,
  output logic                prog_we,
  input  logic                prog_ack,
  output logic [PROM_CNT-1:0] prom_we,
  output logic [7:0]          prom_addr,
  output logic [3:0]          prom_data,
  output logic                dwnld_done,
  output logic                rom_ready,
  output logic                overrun
);

  localparam int          DEPTH     = 1 << FIFO_AW;
  localparam logic [21:0] PROM_END  = PROM_START + 22'(PROM_CNT * 256);
  localparam logic [13:0] PROM_PAGE = PROM_START[21:8];

  // prog_we/prog_ack: prog_we rises with a request and holds address, data and
  // mask stable; the request completes on the first cycle prog_ack is high
  // while prog_we is high, and prog_we drops on the following cycle.

  typedef enum logic [1:0] {ST_IDLE, ST_SDRAM, ST_PROM} state_t;

  state_t               state, state_nx;
  logic [FIFO_AW:0]     wr_ptr, rd_ptr;
  logic [30:0]          mem [DEPTH];
  logic [30:0]          head;
  logic                 full, empty, in_range, push, pop, drop;
  logic [13:0]          prom_idx;
  logic [PROM_CNT-1:0]  prom_sel;
  logic                 dl_q, armed, dl_rise, dl_fall;

  // Entry layout: {is_prom, addr[21:0], data[7:0]}
  assign head     = mem[rd_ptr[FIFO_AW-1:0]];
  assign empty    = wr_ptr == rd_ptr;
  assign full     = (wr_ptr ^ rd_ptr) == {1'b1, {FIFO_AW{1'b0}}};
  assign in_range = ioctl_addr < PROM_END;
  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  assign push     = ioctl_wr && downloading && in_range && (!full || pop);
  assign drop     = ioctl_wr && downloading && in_range && full && !pop;
  assign prom_idx = head[29:16] - PROM_PAGE;
  assign prom_sel = {{(PROM_CNT-1){1'b0}}, 1'b1} << prom_idx;
  assign dl_rise  = downloading && !dl_q;
  assign dl_fall  = !downloading && dl_q;

  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!empty) begin
          pop      = 1'b1;
          state_nx = head[30] ? ST_PROM : ST_SDRAM;
        end
      end
      ST_SDRAM: if (prog_ack) state_nx = ST_IDLE;
      ST_PROM:  state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[FIFO_AW-1:0]] <= {ioctl_addr >= PROM_START, ioctl_addr, ioctl_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + {{FIFO_AW{1'b0}}, 1'b1};
      if (pop)  rd_ptr <= rd_ptr + {{FIFO_AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prog_addr <= '0;
      prog_data <= '0;
      prog_mask <= 2'b11;
      prog_we   <= 1'b0;
      prom_we   <= '0;
      prom_addr <= '0;
      prom_data <= '0;
    end else begin
      prom_we <= '0;
      if (pop) begin
        if (head[30]) begin
          prom_we   <= prom_sel;
          prom_addr <= head[15:8];
          prom_data <= head[3:0];
        end else begin
          prog_addr <= {1'b0, head[29:9]};
          prog_data <= head[7:0];
          prog_mask <= head[8] ? 2'b01 : 2'b10;
          prog_we   <= 1'b1;
        end
      end else if (state == ST_SDRAM && prog_ack) begin
        prog_we <= 1'b0;
      end
    end
  end

  // A new download start cancels any pending completion of the previous one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dl_q       <= 1'b0;
      armed      <= 1'b0;
      dwnld_done <= 1'b0;
      rom_ready  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      dl_q       <= downloading;
      dwnld_done <= 1'b0;
      if (dl_rise) begin
        armed     <= 1'b0;
        rom_ready <= 1'b0;
        overrun   <= 1'b0;
      end else if (dl_fall) begin
        armed <= 1'b1;
      end else if (armed && empty && state == ST_IDLE) begin
        dwnld_done <= 1'b1;
        rom_ready  <= 1'b1;
        armed      <= 1'b0;
      end
      if (drop) overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_jt1943_dwnld_pack.sv
// Bench for jt1943_dwnld_pack: directed ioctl stimulus, expected writes queued
// as they are issued and matched by a monitor when the DUT presents them.
module tb_jt1943_dwnld_pack;

  localparam int W = 40;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        downloading;
  logic [21:0] ioctl_addr;
  logic [7:0]  ioctl_data;
  logic        ioctl_wr;
  logic [21:0] prog_addr;
  logic [7:0]  prog_data;
  logic [1:0]  prog_mask;
  logic        prog_we;
  logic        prog_ack;
  logic [12:0] prom_we;
  logic [7:0]  prom_addr;
  logic [3:0]  prom_data;
  logic        dwnld_done;
  logic        rom_ready;
  logic        overrun;

  jt1943_dwnld_pack dut (
    .clk(clk), .rst_n(rst_n), .downloading(downloading),
    .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data), .ioctl_wr(ioctl_wr),
    .prog_addr(prog_addr), .prog_data(prog_data), .prog_mask(prog_mask),
    .prog_we(prog_we), .prog_ack(prog_ack),
    .prom_we(prom_we), .prom_addr(prom_addr), .prom_data(prom_data),
    .dwnld_done(dwnld_done), .rom_ready(rom_ready), .overrun(overrun)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard state
  logic [W-1:0] exp_q[$];
  int n_tests  = 0;
  int n_fail   = 0;
  int n_prog   = 0;
  int n_prom   = 0;
  int done_cnt = 0;
  bit ack_hold = 1'b0;
  int ack_delay = 1;
  int we_cnt   = 0;
  logic prev_we = 1'b0;
  logic [W-1:0] hold_ev = '0;

  logic [21:0] ov_addr [6] = '{22'h10, 22'h11, 22'h12, 22'h13, 22'h14, 22'h15};
  logic [7:0]  ov_data [6] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15};

  function automatic logic [W-1:0] rom_ev(input logic [21:0] a, input logic [7:0] d,
                                          input logic [1:0] m);
    return {1'b0, 7'b0, a, d, m};
  endfunction

  function automatic logic [W-1:0] prom_ev(input logic [12:0] we, input logic [7:0] a,
                                           input logic [3:0] d);
    return {1'b1, 14'b0, we, a, d};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic compare_event(input string name, input logic [W-1:0] act);
    if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: unexpected output %0h, nothing expected", name, act);
    end else begin
      check(name, act, exp_q.pop_front());
    end
  endtask

  // monitor
  initial begin
    forever begin
      @(negedge clk);
      if (prog_we && !prev_we) begin
        n_prog++;
        hold_ev = rom_ev(prog_addr, prog_data, prog_mask);
        compare_event("prog_write", hold_ev);
      end else if (prog_we) begin
        check("prog_hold", rom_ev(prog_addr, prog_data, prog_mask), hold_ev);
      end
      if (prom_we != '0) begin
        n_prom++;
        compare_event("prom_write", prom_ev(prom_we, prom_addr, prom_data));
      end
      if (dwnld_done) begin
        done_cnt++;
        check("done_after_drain", {exp_q.size() == 0, prog_we}, 2'b10);
      end
      prev_we = prog_we;
    end
  end

  // SDRAM ack responder: ack on the ack_delay-th cycle of a request
  initial begin
    prog_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (prog_we && !ack_hold) begin
        we_cnt++;
        prog_ack = (we_cnt >= ack_delay);
      end else begin
        we_cnt   = 0;
        prog_ack = 1'b0;
      end
    end
  end

  // driver tasks
  task automatic send(input logic [21:0] a, input logic [7:0] d);
    ioctl_addr = a;
    ioctl_data = d;
    ioctl_wr   = 1'b1;
    @(negedge clk);
    ioctl_wr   = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int i;
    for (i = 0; i < 200; i++) begin
      if (exp_q.size() == 0 && !prog_we) break;
      @(negedge clk);
    end
    check(name, i < 200, 1);
    repeat (3) @(negedge clk);
  endtask

  // main sequence
  initial begin
    int p;
    int q;
    rst_n       = 1'b0;
    downloading = 1'b0;
    ioctl_addr  = '0;
    ioctl_data  = '0;
    ioctl_wr    = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_prog", {prog_addr, prog_data, prog_mask, prog_we}, {22'h0, 8'h0, 2'b11, 1'b0});
    check("rst_prom", {prom_we, prom_addr, prom_data}, 0);
    check("rst_status", {dwnld_done, rom_ready, overrun}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    downloading = 1'b1;
    @(negedge clk);

    // ROM byte, ack on the third cycle
    ack_delay = 3;
    exp_q.push_back(rom_ev(22'h00091, 8'hA5, 2'b01));
    send(22'h00123, 8'hA5);
    check("rom_lat_e0", prog_we, 0);
    @(negedge clk);
    check("rom_lat_e1", prog_we, 1);
    repeat (2) @(negedge clk);
    check("rom_held3", {prog_we, prog_addr, prog_mask, prog_data}, {1'b1, 22'h00091, 2'b01, 8'hA5});
    @(negedge clk);
    check("rom_drop", prog_we, 0);

    // PROM byte
    exp_q.push_back(prom_ev(13'h0004, 8'h05, 4'hC));
    send(22'h50205, 8'h3C);
    check("prom_lat_e0", prom_we, 0);
    @(negedge clk);
    check("prom_pulse", {prom_we, prog_we}, {13'h0004, 1'b0});
    @(negedge clk);
    check("prom_one_cycle", prom_we, 0);
    check("prom_hold", {prom_addr, prom_data}, {8'h05, 4'hC});

    // boundaries: last ROM byte, last PROM byte
    ack_delay = 1;
    exp_q.push_back(rom_ev(22'h27FFF, 8'h7E, 2'b01));
    send(22'h4FFFF, 8'h7E);
    exp_q.push_back(prom_ev(13'h1000, 8'hFF, 4'h9));
    send(22'h50CFF, 8'hA9);
    wait_idle("bound_drain");

    // out of range: first address past the PROM area
    p = n_prog;
    q = n_prom;
    send(22'h50D00, 8'h55);
    repeat (5) @(negedge clk);
    check("oor_prog", n_prog, p);
    check("oor_prom", n_prom, q);
    check("oor_overrun", overrun, 0);

    // overrun: 1 in flight, 4 buffered, 6th dropped
    ack_hold = 1'b1;
    p = n_prog;
    exp_q.push_back(rom_ev(22'h08, 8'h10, 2'b10));
    exp_q.push_back(rom_ev(22'h08, 8'h11, 2'b01));
    exp_q.push_back(rom_ev(22'h09, 8'h12, 2'b10));
    exp_q.push_back(rom_ev(22'h09, 8'h13, 2'b01));
    exp_q.push_back(rom_ev(22'h0A, 8'h14, 2'b10));
    for (int i = 0; i < 6; i++) begin
      ioctl_addr = ov_addr[i];
      ioctl_data = ov_data[i];
      ioctl_wr   = 1'b1;
      @(negedge clk);
    end
    ioctl_wr = 1'b0;
    check("ovr_flag", overrun, 1);
    ack_hold = 1'b0;
    wait_idle("ovr_drain");
    check("ovr_writes", n_prog - p, 5);
    check("ovr_sticky", overrun, 1);

    // first completion
    done_cnt = 0;
    downloading = 1'b0;
    repeat (4) @(negedge clk);
    check("first_done", done_cnt, 1);
    check("first_ready", rom_ready, 1);

    // completion with entries queued
    downloading = 1'b1;
    repeat (2) @(negedge clk);
    check("rise_clear", {rom_ready, overrun}, 2'b00);
    done_cnt = 0;
    ack_hold = 1'b1;
    exp_q.push_back(rom_ev(22'h100, 8'h21, 2'b10));
    exp_q.push_back(rom_ev(22'h100, 8'h22, 2'b01));
    exp_q.push_back(rom_ev(22'h101, 8'h23, 2'b10));
    send(22'h200, 8'h21);
    send(22'h201, 8'h22);
    send(22'h202, 8'h23);
    downloading = 1'b0;
    repeat (6) @(negedge clk);
    check("no_early_done", done_cnt, 0);
    check("no_early_ready", rom_ready, 0);
    ack_delay = 2;
    ack_hold  = 1'b0;
    wait_idle("cmp_drain");
    repeat (2) @(negedge clk);
    check("cmp_done_once", done_cnt, 1);
    check("cmp_ready", rom_ready, 1);
    downloading = 1'b1;
    repeat (2) @(negedge clk);
    check("cmp_rise_clear", rom_ready, 0);

    // reset while a write is in flight and the FIFO is full
    ack_hold = 1'b1;
    exp_q.push_back(rom_ev(22'h180, 8'h30, 2'b10));
    for (int i = 0; i < 6; i++) begin
      ioctl_addr = 22'h300 + 22'(i);
      ioctl_data = 8'h30 + 8'(i);
      ioctl_wr   = 1'b1;
      @(negedge clk);
    end
    ioctl_wr = 1'b0;
    check("rst_pre", {prog_we, overrun}, 2'b11);
    rst_n = 1'b0;
    #1;
    check("rst_async", {prog_we, prom_we, overrun, rom_ready}, 0);
    exp_q.delete();
    ack_hold = 1'b0;
    p = n_prog;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("rst_no_write", n_prog, p);
    check("rst_no_we", prog_we, 0);

    check("exp_q_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
